// File: rtl/sram_burst.sv
// Cycle-accurate synchronous SRAM model with valid/ready requests, a programmable
// access latency, byte-enable writes and critical-word-first wrapping read bursts.
module sram_burst #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 512,
    parameter int LATENCY   = 3,
    parameter int BURST_LEN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                rvalid,
    output logic                rlast,
    output logic                wr_done,
    output logic                err
);
    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam logic [ADDR_W-1:0] WRAP_MASK = ADDR_W'(BURST_LEN - 1);
    localparam logic [3:0]        LAST_BEAT = 4'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RBURST, WRESP} state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic [3:0]         beat_q, beat_d;
    logic               req_ready_q, req_ready_d;
    logic               rvalid_q, rvalid_d;
    logic               rlast_q, rlast_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               wr_done_q, wr_done_d;
    logic               err_q, err_d;

    // request fields as seen at the response edge: live inputs when LATENCY=1 skips WAIT
    logic               cur_we;
    logic [ADDR_W-1:0]  cur_addr, beat_addr, rd_addr;
    logic [DATA_W-1:0]  cur_wdata, rd_data, wmerge;
    logic [STRB_W-1:0]  cur_wstrb;
    logic               cur_oor, rd_oor, go_resp, mem_we;

    // address/data datapath: wrapped beat address, range check, read and byte merge
    always_comb begin
        cur_we    = (state_q == IDLE) ? req_we   : we_q;
        cur_addr  = (state_q == IDLE) ? req_addr : addr_q;
        cur_wdata = (state_q == IDLE) ? wdata    : wdata_q;
        cur_wstrb = (state_q == IDLE) ? wstrb    : wstrb_q;
        beat_addr = (addr_q & ~WRAP_MASK) | ((addr_q + ADDR_W'(beat_q)) & WRAP_MASK);
        rd_addr   = (state_q == RBURST) ? beat_addr : cur_addr;
        rd_oor    = {1'b0, rd_addr} >= (ADDR_W + 1)'(DEPTH);
        cur_oor   = {1'b0, cur_addr} >= (ADDR_W + 1)'(DEPTH);
        rd_data   = rd_oor ? '0 : mem_q[rd_addr[IDX_W-1:0]];
        wmerge    = mem_q[cur_addr[IDX_W-1:0]];
        for (int i = 0; i < STRB_W; i++) begin
            if (cur_wstrb[i]) wmerge[i*8 +: 8] = cur_wdata[i*8 +: 8];
        end
    end

    // next-state and next-output logic of the request/response FSM
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        beat_d      = beat_q;
        req_ready_d = req_ready_q;
        rvalid_d    = 1'b0;
        rlast_d     = 1'b0;
        rdata_d     = '0;
        wr_done_d   = 1'b0;
        err_d       = 1'b0;
        go_resp     = 1'b0;
        mem_we      = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                we_d        = req_we;
                addr_d      = req_addr;
                wdata_d     = wdata;
                wstrb_d     = wstrb;
                req_ready_d = 1'b0;
                if (LATENCY == 1) go_resp = 1'b1;
                else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                // the edge that takes the counter to zero is the one entering the response
                if (cnt_q == CNT_W'(1)) go_resp = 1'b1;
                else cnt_d = cnt_q - 1'b1;
            end
            RBURST: begin
                if (rlast_q) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                end else begin
                    rvalid_d = 1'b1;
                    rlast_d  = (beat_q == LAST_BEAT);
                    rdata_d  = rd_data;
                    err_d    = rd_oor;
                    beat_d   = beat_q + 1'b1;
                end
            end
            WRESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (go_resp) begin
            err_d = cur_oor;
            if (cur_we) begin
                state_d   = WRESP;
                wr_done_d = 1'b1;
                mem_we    = !cur_oor;
            end else begin
                // first beat is the requested word itself
                state_d  = RBURST;
                rvalid_d = 1'b1;
                rlast_d  = (BURST_LEN == 1);
                rdata_d  = rd_data;
                beat_d   = 4'd1;
            end
        end
    end

    // FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            beat_q      <= '0;
            req_ready_q <= 1'b1;
            rvalid_q    <= 1'b0;
            rlast_q     <= 1'b0;
            rdata_q     <= '0;
            wr_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            beat_q      <= beat_d;
            req_ready_q <= req_ready_d;
            rvalid_q    <= rvalid_d;
            rlast_q     <= rlast_d;
            rdata_q     <= rdata_d;
            wr_done_q   <= wr_done_d;
            err_q       <= err_d;
        end
    end

    // storage array: cleared by reset, written on the edge entering WRESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[cur_addr[IDX_W-1:0]] <= wmerge;
        end
    end

    assign req_ready = req_ready_q;
    assign rvalid    = rvalid_q;
    assign rlast     = rlast_q;
    assign rdata     = rdata_q;
    assign wr_done   = wr_done_q;
    assign err       = err_q;
endmodule

// File: tb/tb_sram_burst.sv
// Bench for sram_burst: table of requests with expected responses, a scoreboard
// queue checked cycle-by-cycle, plus hand sequences for handshake, reset and LATENCY=1.
module tb_sram_burst;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance (LATENCY=3, BURST_LEN=2)
    logic        req_valid = 0, req_we = 0;
    logic        req_ready, rvalid, rlast, wr_done, err;
    logic [15:0] req_addr = 0;
    logic [31:0] wdata = 0, rdata;
    logic [3:0]  wstrb = 0;

    sram_burst #(.LATENCY(3), .BURST_LEN(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .wr_done(wr_done), .err(err));

    // second instance with LATENCY=1
    logic        v1 = 0, we1 = 0;
    logic        ready1, rvalid1, rlast1, wr_done1, err1;
    logic [15:0] a1 = 0;
    logic [31:0] wd1 = 0, rdata1;
    logic [3:0]  ws1 = 0;

    sram_burst #(.LATENCY(1), .BURST_LEN(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(ready1),
        .req_we(we1), .req_addr(a1), .wdata(wd1), .wstrb(ws1),
        .rdata(rdata1), .rvalid(rvalid1), .rlast(rlast1), .wr_done(wr_done1), .err(err1));

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        logic        err;
        logic        last;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wd;
        logic [3:0]  ws;
        logic        e0;
        logic [31:0] d0;
        logic        e1;
        logic [31:0] d1;
    } vec_t;

    exp_t        sb[$];
    vec_t        tbl[14];
    logic [31:0] mdl[512];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // compare whatever the main DUT shows in this cycle against the scoreboard
    task automatic monitor();
        exp_t e;
        if (!rst_n) return;
        if (rvalid || wr_done) begin
            if (sb.size() == 0) chk("unexpected_resp", {rvalid, wr_done}, 2'b00);
            else begin
                e = sb.pop_front();
                chk("resp_kind", {rvalid, wr_done}, e.is_rd ? 2'b10 : 2'b01);
                if (e.is_rd) begin
                    chk("rdata", rdata, e.data);
                    chk("rlast", rlast, e.last);
                end
                chk("err", err, e.err);
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
            end
        end else begin
            chk("idle_outputs", {rdata, rlast}, 33'd0);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    function automatic logic [15:0] beat1(input logic [15:0] a);
        return (a & ~16'd1) | ((a + 16'd1) & 16'd1);
    endfunction

    function automatic logic [31:0] mrd(input logic [15:0] a);
        return (a < 16'd512) ? mdl[a[8:0]] : 32'd0;
    endfunction

    // drive a request, wait for acceptance, push expectations, update model
    task automatic accept(input logic we, input logic [15:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic push, input logic e0,
                          input logic [31:0] d0, input logic e1, input logic [31:0] d1,
                          output int n);
        req_valid = 1; req_we = we; req_addr = a; wdata = d; wstrb = s;
        for (int t = 0; !req_ready; t++) begin
            if (t > 30) begin
                $display("FAIL accept_timeout: req_ready never returned (cycle %0d)", cyc);
                errors++;
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $fatal(1, "timeout");
            end
            tick();
        end
        n = cyc + 1;
        if (push) begin
            if (we) sb.push_back('{1'b0, 32'd0, e0, 1'b0, n + 2});
            else begin
                sb.push_back('{1'b1, d0, e0, 1'b0, n + 2});
                sb.push_back('{1'b1, d1, e1, 1'b1, n + 3});
            end
        end
        if (we && a < 16'd512)
            for (int i = 0; i < 4; i++) if (s[i]) mdl[a[8:0]][i*8 +: 8] = d[i*8 +: 8];
        tick();
        req_valid = 0;
    endtask

    // check busy in cycle k and that req_ready returns exactly when expected
    task automatic wait_idle(input int n, input logic we);
        chk("busy_k", req_ready, 1'b0);
        for (int t = 0; t < 20 && !req_ready; t++) tick();
        chk("ready_return", 64'(cyc), 64'(n + (we ? 3 : 4)));
    endtask

    task automatic rd_model(input logic [15:0] a, output int n);
        logic [15:0] b = beat1(a);
        accept(1'b0, a, 32'd0, 4'd0, 1'b1, a >= 16'd512, mrd(a), b >= 16'd512, mrd(b), n);
    endtask

    initial begin
        int n, n2;
        for (int i = 0; i < 512; i++) mdl[i] = 32'd0;
        tbl[0]  = '{0, 16'd5,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
        tbl[1]  = '{1, 16'd6,   32'hDEADBEEF, 4'hF, 0, 32'h0,        0, 32'h0};
        tbl[2]  = '{0, 16'd7,   32'h0,        4'h0, 0, 32'h0,        0, 32'hDEADBEEF};
        tbl[3]  = '{1, 16'd6,   32'h11223344, 4'h5, 0, 32'h0,        0, 32'h0};
        tbl[4]  = '{0, 16'd6,   32'h0,        4'h0, 0, 32'hDE22BE44, 0, 32'h0};
        tbl[5]  = '{1, 16'd512, 32'hCAFEF00D, 4'hF, 1, 32'h0,        0, 32'h0};
        tbl[6]  = '{0, 16'd600, 32'h0,        4'h0, 1, 32'h0,        1, 32'h0};
        tbl[7]  = '{0, 16'd0,   32'h0,        4'h0, 0, 32'h0,        0, 32'h0};
        tbl[8]  = '{1, 16'd511, 32'hAABBCCDD, 4'hF, 0, 32'h0,        0, 32'h0};
        tbl[9]  = '{0, 16'd510, 32'h0,        4'h0, 0, 32'h0,        0, 32'hAABBCCDD};
        tbl[10] = '{1, 16'd1,   32'h12FFFFFF, 4'h8, 0, 32'h0,        0, 32'h0};
        tbl[11] = '{1, 16'd0,   32'hFFFFFFFF, 4'h0, 0, 32'h0,        0, 32'h0};
        tbl[12] = '{0, 16'd1,   32'h0,        4'h0, 0, 32'h12000000, 0, 32'h0};
        tbl[13] = '{0, 16'd511, 32'h0,        4'h0, 0, 32'hAABBCCDD, 0, 32'h0};

        // reset held for two cycles, outputs checked while in reset
        #1 rst_n = 0;
        tick();
        tick();
        chk("rst_outputs", {req_ready, rvalid, rlast, wr_done, err, rdata}, {5'b10000, 32'd0});
        #2 rst_n = 1;

        // table-driven requests
        foreach (tbl[i]) begin
            accept(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].ws, 1'b1,
                   tbl[i].e0, tbl[i].d0, tbl[i].e1, tbl[i].d1, n);
            wait_idle(n, tbl[i].we);
        end

        // new request held valid during a busy read: accepted only once ready returns
        rd_model(16'd6, n);
        accept(1'b1, 16'd7, 32'h55555555, 4'hF, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, n2);
        chk("held_accept_edge", 64'(n2), 64'(n + 5));
        wait_idle(n2, 1'b1);
        rd_model(16'd7, n);
        wait_idle(n, 1'b0);

        // reset one cycle after accepting a write: pulse dropped, memory cleared
        accept(1'b1, 16'd2, 32'h12345678, 4'hF, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, n);
        wait_idle(n, 1'b1);
        accept(1'b1, 16'd3, 32'h77777777, 4'hF, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, n);
        rst_n = 0;
        #1 chk("mid_rst_outputs", {req_ready, rvalid, rlast, wr_done}, 4'b1000);
        #1 rst_n = 1;
        for (int i = 0; i < 512; i++) mdl[i] = 32'd0;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("no_wr_done_after_rst", wr_done, 1'b0);
        end
        accept(1'b0, 16'd3, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, n);
        wait_idle(n, 1'b0);
        accept(1'b0, 16'd6, 32'd0, 4'd0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, n);
        wait_idle(n, 1'b0);

        // LATENCY=1 instance: responses start in the cycle right after acceptance
        chk("l1_ready_idle", ready1, 1'b1);
        v1 = 1; we1 = 1; a1 = 16'd2; wd1 = 32'h0BADF00D; ws1 = 4'hF;
        tick();
        v1 = 0;
        chk("l1_wr_k", {wr_done1, err1, ready1}, 3'b100);
        tick();
        chk("l1_wr_k1", {wr_done1, ready1}, 2'b01);
        v1 = 1; we1 = 0; a1 = 16'd3;
        tick();
        v1 = 0;
        chk("l1_beat0", {rvalid1, rlast1, err1, ready1, rdata1}, {4'b1000, 32'h0});
        tick();
        chk("l1_beat1", {rvalid1, rlast1, err1, ready1, rdata1}, {4'b1100, 32'h0BADF00D});
        tick();
        chk("l1_done", {rvalid1, rlast1, ready1, rdata1}, {3'b001, 32'h0});

        tick();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_burst.md
Name: sram_burst

Overview:
Parametrised, cycle-accurate synchronous SRAM model that replaces fixed-delay combinational-read memory in the cache/memory subsystem.
- Valid/ready request handshake; one request outstanding at a time.
- Programmable access latency counted in clock cycles, with no absolute-time delays.
- Byte-enable writes.
- Wrapping read bursts for cache line fills.
- Sits between the cache controller and the backing store.

Parameters:
DATA_W, 32, data word width in bits; multiple of 8.
ADDR_W, 16, word-address width.
DEPTH, 512, number of words implemented; valid addresses are 0..DEPTH-1.
LATENCY, 3, cycles from request acceptance to first response; minimum 1.
BURST_LEN, 2, read beats per request; power of 2, 1..8.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous reset, active-low.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_we  in  1  1 = write, 0 = read burst.
req_addr  in  ADDR_W  word address.
wdata  in  DATA_W  write data.
wstrb  in  DATA_W/8  byte enables; bit i covers byte lane i.
rdata  out  DATA_W  read beat data; 0 when rvalid = 0.
rvalid  out  1  read beat valid.
rlast  out  1  final beat of a burst.
wr_done  out  1  one-cycle write completion pulse.
err  out  1  out-of-range flag, qualified by rvalid or wr_done.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - All DEPTH words cleared to 0; state IDLE.
  - Outputs: req_ready = 1, rvalid = 0, rlast = 0, rdata = 0, wr_done = 0, err = 0.
- States: IDLE, WAIT, RBURST, WRESP.
- Acceptance: at a rising edge in IDLE with req_valid = 1, req_ready = 1.
  - Capture req_we, req_addr, wdata and wstrb.
  - Load the latency counter with LATENCY-1; go to WAIT.
  - req_ready = 0 from the next cycle. Cycle k denotes the cycle after the accepting edge.
- req_valid while req_ready = 0: ignored, not queued; inputs are not sampled.
- WAIT: decrement the counter each edge. On reaching 0, go to RBURST (read) or WRESP (write).
  - LATENCY = 1 skips WAIT, so the response appears in cycle k.
- Write (WRESP):
  - Memory is updated at the edge entering WRESP; only lanes with wstrb = 1 change.
  - wr_done = 1 for exactly one cycle, cycle k+LATENCY-1.
  - Next edge: IDLE, req_ready = 1.
  - wstrb = 0: no memory change, wr_done still pulses.
- Read (RBURST):
  - Beats are driven in cycles k+LATENCY-1 .. k+LATENCY+BURST_LEN-2, one per cycle. No backpressure; rvalid stays continuously high across the burst.
  - Beat j address = (addr & ~(BURST_LEN-1)) | ((addr + j) & (BURST_LEN-1)). This is critical-word-first with wrap inside the aligned block.
  - rlast = 1 only on the final beat. BURST_LEN = 1 gives rvalid = rlast = 1 for one cycle.
  - req_ready = 1 in the cycle after rlast.
- Out of range: an address (or wrapped beat address) >= DEPTH.
  - Read beat: rdata = 0, err = 1 for that beat.
  - Write: memory untouched; err = 1 together with wr_done.
  - In-range beats of the same burst return normal data with err = 0.
- Address arithmetic uses the word index only; no byte offset or base address is applied.
- Reset mid-operation: rvalid, rlast and wr_done deassert immediately; the pending write is dropped; memory is cleared.
- After rst_n rises, the first acceptance is possible at the first clock edge.

Test Plan:
1. Reset then idle: rst_n low for 2 cycles.
   -> All outputs at reset values, req_ready = 1; reading addr 5 returns 0 for both beats.
2. Full write then burst read (LATENCY = 3, BURST_LEN = 2):
   - Write addr 6, wdata 0xDEADBEEF, wstrb 0xF -> wr_done in cycle k+2, req_ready high in k+3.
   - Read addr 7 -> beats [mem[7] = 0, mem[6] = 0xDEADBEEF] in k+2 and k+3, rlast on the second beat.
3. Byte-enable write: addr 6 holds 0xDEADBEEF; write 0x11223344 with wstrb 0x5.
   -> A later read of addr 6 returns 0xDE22BE44.
4. Out of range:
   - Write to addr 512 -> err = 1 with wr_done; no word in memory changes.
   - Read addr 600 -> both beats rdata = 0, err = 1.
5. Handshake abuse: hold req_valid = 1 with a new request during a busy read.
   -> That request is not accepted until req_ready returns. Second run with LATENCY = 1: read response starts in cycle k.
6. Reset in WAIT: assert rst_n low one cycle after accepting a write to addr 3.
   -> No wr_done pulse; after release, a read of addr 3 returns 0.
